// File: rtl/spi_receiver.sv
// spi_receiver: SPI mode-0 target receiver, MSB first, CS active-low, sampled in clk_100.
// De-serialises words onto a valid/ready output with overrun and framing-error pulses.
module spi_receiver #(
   parameter int P_DATA_WIDTH  = 16,
   parameter int P_SYNC_STAGES = 2
) (
   input  logic                    clk_100,
   input  logic                    a_rst,
   input  logic                    sck_in,
   input  logic                    cs_n,
   input  logic                    mosi,
   input  logic                    ready_i,
   output logic                    valid_o,
   output logic [P_DATA_WIDTH-1:0] data_o,
   output logic                    overrun_o,
   output logic                    frame_err_o,
   output logic                    busy_o
);
   localparam int CW = $clog2(P_DATA_WIDTH);
   typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;
   state_t                   state;
   logic [P_SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, primed;
   logic                     sck_prev, sck_s, cs_s, mosi_s, bit_in, done;
   logic [CW-1:0]            cnt, cnt_next;
   logic [P_DATA_WIDTH-1:0]  shift_reg, word;
   always_ff @(posedge clk_100 or posedge a_rst) begin
      if (a_rst) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         primed    <= '0;
         sck_prev  <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[P_SYNC_STAGES-2:0], sck_in};
         cs_sync   <= {cs_sync[P_SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[P_SYNC_STAGES-2:0], mosi};
         primed    <= {primed[P_SYNC_STAGES-2:0], 1'b1};
         sck_prev  <= sck_s;
      end
   end
   always_comb begin
      sck_s    = sck_sync[P_SYNC_STAGES-1];
      cs_s     = cs_sync[P_SYNC_STAGES-1];
      mosi_s   = mosi_sync[P_SYNC_STAGES-1];
      bit_in   = (state == SHIFT) && sck_s && !sck_prev;
      done     = bit_in && (cnt == CW'(P_DATA_WIDTH-1));
      cnt_next = !bit_in ? cnt : done ? '0 : cnt + 1'b1;
      word     = {shift_reg[P_DATA_WIDTH-2:0], mosi_s};
   end
   always_ff @(posedge clk_100 or posedge a_rst) begin
      if (a_rst) begin
         state       <= WAIT_IDLE;
         cnt         <= '0;
         shift_reg   <= '0;
         valid_o     <= 1'b0;
         data_o      <= '0;
         overrun_o   <= 1'b0;
         frame_err_o <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         if (done && (!valid_o || ready_i)) begin
            data_o  <= word;
            valid_o <= 1'b1;
         end else begin
            overrun_o <= done;
            if (ready_i) valid_o <= 1'b0;
         end
         case (state)
            // Sync stages still hold reset values until flushed, so only trust CS once primed.
            WAIT_IDLE: if (primed[P_SYNC_STAGES-1] && cs_s) state <= IDLE;
            IDLE: begin
               cnt       <= '0;
               shift_reg <= '0;
               if (!cs_s) begin
                  state  <= SHIFT;
                  busy_o <= 1'b1;
               end
            end
            SHIFT: begin
               if (bit_in) shift_reg <= word;
               cnt <= cnt_next;
               if (cs_s) begin
                  state       <= IDLE;
                  busy_o      <= 1'b0;
                  frame_err_o <= (cnt_next != '0);
               end
            end
            default: state <= WAIT_IDLE;
         endcase
      end
   end
endmodule

// File: doc/spi_receiver.md
# spi_receiver

SPI target-side receiver: the far end of the link driven by `transmitter`. It samples an external SPI bus (mode 0, MSB first, CS active-low) in the `clk_100` domain and de-serialises `P_DATA_WIDTH`-bit words. Each word is presented on a valid/ready output handshake, and overrun and framing errors are flagged. It sits on the receiving board, or in a loopback bench, between the SPI pins and a word consumer.

## Interface
- `P_DATA_WIDTH`, default 16: bits per word; must be ≥ 2.
- `P_SYNC_STAGES`, default 2: synchroniser depth for `sck_in`, `cs_n`, `mosi`; must be ≥ 2.
- `clk_100` in 1: system clock, all logic on its rising edge.
- `a_rst` in 1: reset, asynchronous and active-high.
- `sck_in` in 1: SPI clock from the bus, asynchronous.
- `cs_n` in 1: chip select, active-low, asynchronous.
- `mosi` in 1: serial data, asynchronous.
- `ready_i` in 1: consumer accepts `data_o` when high together with `valid_o`.
- `valid_o` out 1: `data_o` holds an unconsumed word.
- `data_o` out `P_DATA_WIDTH`: received word; first bit received is the MSB.
- `overrun_o` out 1: one-cycle pulse; a completed word was dropped.
- `frame_err_o` out 1: one-cycle pulse; CS rose mid-word.
- `busy_o` out 1: high while in `SHIFT`.

## Operation
- All three bus inputs pass through identical `P_SYNC_STAGES` flop chains. Sync reset values: `sck`=0, `cs_n`=1, `mosi`=0.
- An extra register holds the previous synced `sck`. SCK rise = synced high and previous low. SCK falling edges are ignored (mode 0).
- FSM:
  - `WAIT_IDLE` (reset state): go to `IDLE` when synced `cs_n`=1.
  - `IDLE`: go to `SHIFT` when synced `cs_n`=0. Clear bit counter and shift register.
  - `SHIFT`: on each SCK rise, shift synced `mosi` into the LSB and increment the counter. When `cs_n`=1, go to `IDLE`.
- Bit counter width is clog2(`P_DATA_WIDTH`). On the SCK rise that delivers bit `P_DATA_WIDTH`, the counter wraps to 0 and the word completes. Several words per CS assertion are allowed.
- Word completion:
  - If the output slot is free, or is being accepted in the same cycle, load `data_o` with `{shift[W-2:0], mosi}` and set `valid_o`=1 on that edge.
  - Otherwise drop the new word, keep `data_o` unchanged, and pulse `overrun_o`.
- Handshake: a transfer occurs on an edge with `valid_o`&`ready_i`. After a transfer, `valid_o` goes to 0 unless a word completes on the same edge, in which case it stays 1 with new data.
- `data_o` is stable while `valid_o`=1 and not accepted.
- CS rising (synced) in `SHIFT`:
  - counter ≠ 0: discard the partial word and pulse `frame_err_o`.
  - counter = 0: no error.
- SCK rise and CS rise in the same cycle: process the bit first, then the CS rule.
- SCK activity while not in `SHIFT` is ignored.
- Reset mid-operation: return to `WAIT_IDLE` and discard any partial word. No word is accepted until CS is observed high, then low.

## Timing
- Reset values: `valid_o`=0, `data_o`=0, `overrun_o`=0, `frame_err_o`=0, `busy_o`=0, FSM=`WAIT_IDLE`, counter=0.
- Pin-to-action latency: a pin transition is acted on at the (`P_SYNC_STAGES`+1)th `clk_100` edge after it becomes stable. This is 3 edges at the default.
- `mosi` and `sck` see equal latency, so `mosi` must be stable across the SCK rise (setup/hold) for at least 1 `clk_100` period each side.
- Bus limits: `sck_in` high and low phases each ≥ 4 `clk_100` periods, i.e. SCK ≤ 12.5 MHz. CS setup before the first SCK rise, and hold after the last, ≥ 4 periods.
- `valid_o` rises on the same edge as the final bit shift. Last SCK rise at the pin to `valid_o` is 3 cycles.
- `overrun_o` and `frame_err_o` pulse exactly 1 cycle, registered on the edge of the causing event.
- `busy_o` is registered and follows the FSM state.

## Test plan
- `P_DATA_WIDTH`=16, `ready_i`=1, send 0xA5C3 at SCK = `clk_100`/8 → exactly one `valid_o` cycle with `data_o`=0xA5C3; no error pulses; `busy_o` low after CS rises.
- `ready_i`=0, send 0x1234 then 0xBEEF in one CS frame → `valid_o` held with 0x1234; one `overrun_o` pulse at the second completion. Raising `ready_i` later transfers 0x1234, then `valid_o`=0.
- `ready_i` raised on the exact edge the second word 0x00FF completes → `valid_o` stays 1 with `data_o`=0x00FF; no overrun.
- CS rises after 5 bits, then a full 0x8001 is sent → one `frame_err_o` pulse, no `valid_o` for the partial word, then `data_o`=0x8001.
- Assert `a_rst` after 8 bits with CS held low, release, clock 16 more bits → no `valid_o`. After a CS high→low and 0x5A5A, `data_o`=0x5A5A.
- Toggle `sck_in` 20 times with `cs_n`=1 → all outputs stay at reset values.
